// File: rtl/sub_ser_clk_if.sv
// Start/done handshake and operand/result bundle for the serial slice subtractor.
// The master side issues operations; the slave side computes and reports results.
interface sub_ser_clk_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo
    );
endinterface

// File: rtl/sub_ser_clk.sv
// Multi-cycle subtractor d = a - b - bi, evaluated one SLICE-bit slice per clock, LSB first.
// The difference is formed as a + ~b + ~bi, with the carry rippling between slices through a register.
//
// state | meaning
// IDLE  | waiting for start; d/bo hold the last completed result
// CALC  | one slice per edge; busy high
// DONE  | one-cycle done pulse, then back to IDLE
module sub_ser_clk #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    sub_ser_clk_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_nb;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] part_next;
    logic [WIDTH-1:0] d_r;
    logic             carry;
    logic             busy_r;
    logic             done_r;
    logic             bo_r;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] nb_sl;
    logic [SLICE:0]   sum_sl;

    // Slice selection uses constant part-selects so the mux stays explicit.
    always_comb begin
        a_sl      = '0;
        nb_sl     = '0;
        part_next = part;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt == CW'(i)) begin
                a_sl  = op_a[i*SLICE +: SLICE];
                nb_sl = op_nb[i*SLICE +: SLICE];
            end
        end
        sum_sl = {1'b0, a_sl} + {1'b0, nb_sl} + {{SLICE{1'b0}}, carry};
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt == CW'(i)) begin
                part_next[i*SLICE +: SLICE] = sum_sl[SLICE-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_nb  <= '0;
            part   <= '0;
            d_r    <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bo_r   <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_nb  <= ~bus.b;
                        carry  <= ~bus.bi;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    part  <= part_next;
                    carry <= sum_sl[SLICE];
                    cnt   <= cnt + CW'(1);
                    // The final slice publishes the full result in the same edge, so d never shows partial slices.
                    if (cnt == LAST) begin
                        d_r    <= part_next;
                        bo_r   <= ~sum_sl[SLICE];
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = d_r;
    assign bus.bo   = bo_r;
endmodule

// File: tb/tb_sub_ser_clk.sv
// Self-checking bench for sub_ser_clk: directed corner cases plus random operations
// compared against a plain 33-bit arithmetic model of a - b - bi.
module tb_sub_ser_clk;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] prev_d;
    logic        prev_bo;

    sub_ser_clk_if #(.WIDTH(32)) bus ();

    sub_ser_clk #(.WIDTH(32), .SLICE(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to completion; optionally pulse a second start mid-CALC.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbi, input bit inject);
        logic [32:0] r;
        int          n;
        r = {1'b0, ta} - {1'b0, tb_v} - 33'(tbi);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.bi    = tbi;
        @(posedge clk);
        #1;
        check("busy_at_start", 64'(bus.busy), 64'(1));
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.bi    = 1'($urandom);
        n = 0;
        while (n < 4 || (!bus.done && n < 10)) begin
            check("d_hold", 64'(bus.d), 64'(prev_d));
            check("bo_hold", 64'(bus.bo), 64'(prev_bo));
            if (inject && n == 1) begin
                bus.start = 1'b1;
                bus.a     = 32'h1;
                bus.b     = 32'h1;
                bus.bi    = 1'b0;
            end
            if (inject && n == 2) bus.start = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (n < 4) begin
                check("busy_calc", 64'(bus.busy), 64'(1));
                check("done_early", 64'(bus.done), 64'(0));
            end
        end
        check("latency", 64'(n), 64'(4));
        check("done_pulse", 64'(bus.done), 64'(1));
        check("busy_at_done", 64'(bus.busy), 64'(0));
        check("d", 64'(bus.d), 64'(r[31:0]));
        check("bo", 64'(bus.bo), 64'(r[32]));
        prev_d  = r[31:0];
        prev_bo = r[32];
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus.done), 64'(0));
        check("busy_idle", 64'(bus.busy), 64'(0));
        if (inject) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check("no_queued_op", 64'({bus.busy, bus.done}), 64'(0));
                check("d_after_ignored", 64'(bus.d), 64'(prev_d));
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        prev_d    = '0;
        prev_bo   = 1'b0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bi    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_d", 64'(bus.d), 64'(0));
        check("rst_bo", 64'(bus.bo), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);
        run_op(32'h135F_A562, 32'h3561_4642, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);

        // Abort during the second CALC cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h7777_7777;
        bus.b     = 32'h1111_1111;
        bus.bi    = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_d", 64'(bus.d), 64'(0));
        check("abort_bo", 64'(bus.bo), 64'(0));
        prev_d  = '0;
        prev_bo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 64'(bus.done), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            run_op(ra, rb, 1'($urandom), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
